// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encoding, counter widths and
// default timing constants used by both the host transmitter and the receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_REQ     = 3'd2,
    ST_XFER    = 3'd3,
    ST_DONE    = 3'd4
  } ps2_state_e;

  localparam int unsigned DEF_CLK_FREQ   = 50_000_000;
  localparam int unsigned DEF_INHIBIT_US = 100;
  localparam int unsigned DEF_TIMEOUT_US = 15_000;

  localparam int unsigned EDGE_CNT_W = 4;
  localparam int unsigned TO_CNT_W   = 20;
  localparam logic [EDGE_CNT_W-1:0] LAST_EDGE = 4'd11;

  // Whole-MHz clocks only; fractional MHz is truncated.
  function automatic int unsigned us_to_cyc(input int unsigned clk_freq,
                                            input int unsigned us);
    return (clk_freq / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop synchronisers for the PS/2 clock and data lines plus falling-edge
// detect on the synchronised clock. Lines idle high, so the chains reset to 1.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_fall,
  output logic data_sync
);

  logic [2:0] clk_sync_q, clk_sync_d;
  logic [2:0] data_sync_q, data_sync_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk_in};
    data_sync_d = {data_sync_q[1:0], ps2_data_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= 3'b111;
      data_sync_q <= 3'b111;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
    end
  end

  // Oldest sample high, next-oldest low.
  assign clk_fall  = clk_sync_q[2] & ~clk_sync_q[1];
  assign data_sync = data_sync_q[2];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues a
// request-to-send, shifts the byte out on device clock edges and checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = DEF_CLK_FREQ,
  parameter int unsigned INHIBIT_CYC = us_to_cyc(CLK_FREQ, DEF_INHIBIT_US),
  parameter int unsigned TIMEOUT_CYC = us_to_cyc(CLK_FREQ, DEF_TIMEOUT_US)
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       timeout_err,
  output ps2_state_e state_dbg
);

  localparam logic [TO_CNT_W-1:0] INHIBIT_LAST = TO_CNT_W'(INHIBIT_CYC - 1);
  localparam logic [TO_CNT_W-1:0] TIMEOUT_LAST = TO_CNT_W'(TIMEOUT_CYC - 1);

  ps2_state_e            state_q, state_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  parity_q, parity_d;
  logic [TO_CNT_W-1:0]   cnt_q, cnt_d;
  logic [EDGE_CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic                  data_oe_q, data_oe_d;
  logic                  ack_ok_q, ack_ok_d;
  logic                  timeout_err_q, timeout_err_d;

  logic clk_fall, data_sync;
  logic edge_last, timeout_hit;

  ps2_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (clrn),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .clk_fall   (clk_fall),
    .data_sync  (data_sync)
  );

  assign edge_last   = (state_q == ST_XFER) && clk_fall && (edge_cnt_q == LAST_EDGE - 4'd1);
  assign timeout_hit = (state_q == ST_XFER) && (cnt_q >= TIMEOUT_LAST);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q       <= ST_IDLE;
      tx_byte_q     <= '0;
      parity_q      <= 1'b0;
      cnt_q         <= '0;
      edge_cnt_q    <= '0;
      data_oe_q     <= 1'b0;
      ack_ok_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_byte_q     <= tx_byte_d;
      parity_q      <= parity_d;
      cnt_q         <= cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      data_oe_q     <= data_oe_d;
      ack_ok_q      <= ack_ok_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // The eleventh edge takes priority over a coincident timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (tx_start) state_d = ST_INHIBIT;
      ST_INHIBIT: if (cnt_q == INHIBIT_LAST) state_d = ST_REQ;
      ST_REQ:     state_d = ST_XFER;
      ST_XFER:    if (edge_last || timeout_hit) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_byte_d     = tx_byte_q;
    parity_d      = parity_q;
    cnt_d         = cnt_q;
    edge_cnt_d    = edge_cnt_q;
    data_oe_d     = data_oe_q;
    ack_ok_d      = ack_ok_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        cnt_d     = '0;
        if (tx_start) begin
          tx_byte_d     = tx_data;
          parity_d      = ~^tx_data;
          ack_ok_d      = 1'b0;
          timeout_err_d = 1'b0;
        end
      end
      ST_INHIBIT: cnt_d = cnt_q + 20'd1;
      ST_REQ: begin
        cnt_d      = '0;
        edge_cnt_d = '0;
        data_oe_d  = 1'b1;
      end
      ST_XFER: begin
        cnt_d = cnt_q + 20'd1;
        if (clk_fall) begin
          if (edge_cnt_q != LAST_EDGE) edge_cnt_d = edge_cnt_q + 4'd1;
          if (edge_cnt_q < 4'd8)       data_oe_d  = ~tx_byte_q[edge_cnt_q[2:0]];
          else if (edge_cnt_q == 4'd8) data_oe_d  = ~parity_q;
          else                         data_oe_d  = 1'b0;
          if (edge_cnt_q == LAST_EDGE - 4'd1) ack_ok_d = ~data_sync;
        end
        if (timeout_hit && !edge_last) begin
          data_oe_d     = 1'b0;
          ack_ok_d      = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      ST_DONE: data_oe_d = 1'b0;
      default: data_oe_d = 1'b0;
    endcase
  end

  always_comb begin
    ps2_clk_oe  = (state_q == ST_INHIBIT);
    ps2_data_oe = (state_q == ST_REQ) || ((state_q == ST_XFER) && data_oe_q);
    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    ack_ok      = ack_ok_q;
    timeout_err = timeout_err_q;
    state_dbg   = state_q;
  end

endmodule
